// File: rtl/uart_pkg.sv
// Shared definitions for the board UART byte transmitter and receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int UART_DATA_BITS = 8;

    // Last value of the bit-period counter; TX and RX must agree on this.
    function automatic int baud_mcnt(input int clock_freq, input int baud);
        return clock_freq / baud - 1;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Brings the asynchronous uart_rx pin into the clock domain and flags
// its high-to-low transitions for the receive FSM.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_dly;

    // Reset to the idle-high level so leaving reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_dly  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep this a true three-stage chain.
            r_meta <= i_rx;
            r_sync <= r_meta;
            r_dly  <= r_sync;
        end
    end

    assign o_rx_s = r_sync;
    assign o_fall = r_dly & ~r_sync;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver with one-cycle rx_done / frame_err strobes.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around mid-bit.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int clock_freq = 50_000_000,
    parameter int baud       = 9600,
    parameter int mcnt_baud  = baud_mcnt(clock_freq, baud),
    parameter int mcnt_mid   = mcnt_baud / 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] data,
    output logic       rx_done,
    output logic       frame_err
);

    localparam logic [29:0] C_MCNT_BAUD = 30'(mcnt_baud);
    localparam logic [29:0] C_MID       = 30'(mcnt_mid);
    localparam logic [3:0]  C_LAST_BIT  = 4'(UART_DATA_BITS - 1);

    logic        w_rx_s;
    logic        w_fall;
    logic        w_bit;

    uart_state_t r_state;
    logic [29:0] r_baud_cnt;
    logic [3:0]  r_bit_cnt;
    logic [UART_DATA_BITS-1:0] r_shift_reg;

    uart_rx_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .i_rx   (uart_rx),
        .o_rx_s (w_rx_s),
        .o_fall (w_fall)
    );

`ifdef UART_RX_MAJORITY_EN
    // Decisions wait one extra count so the third sample is available.
    localparam logic [29:0] C_SAMPLE = C_MID + 30'd1;

    logic r_maj_a;
    logic r_maj_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_maj_a <= 1'b1;
            r_maj_b <= 1'b1;
        end else begin
            if (r_baud_cnt == C_MID - 30'd1) r_maj_a <= w_rx_s;
            if (r_baud_cnt == C_MID)         r_maj_b <= w_rx_s;
        end
    end

    assign w_bit = (r_maj_a & r_maj_b) | (r_maj_a & w_rx_s) | (r_maj_b & w_rx_s);
`else
    localparam logic [29:0] C_SAMPLE = C_MID;

    assign w_bit = w_rx_s;
`endif

    // NOTE: r_shift_reg carries no reset; it is always fully rewritten before data loads it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            data       <= '0;
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;

            if (r_state == IDLE || r_baud_cnt == C_MCNT_BAUD)
                r_baud_cnt <= '0;
            else
                r_baud_cnt <= r_baud_cnt + 30'd1;

            case (r_state)
                IDLE: begin
                    if (w_fall) r_state <= START;
                end
                START: begin
                    if (r_baud_cnt == C_SAMPLE && w_bit) begin
                        r_state    <= IDLE;
                        r_baud_cnt <= '0;
                    end else if (r_baud_cnt == C_MCNT_BAUD) begin
                        r_state   <= DATA;
                        r_bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (r_baud_cnt == C_SAMPLE)
                        r_shift_reg[r_bit_cnt[2:0]] <= w_bit;
                    if (r_baud_cnt == C_MCNT_BAUD) begin
                        if (r_bit_cnt == C_LAST_BIT)
                            r_state <= STOP;
                        else
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                end
                STOP: begin
                    // Leave half a bit early so a back-to-back start edge is caught.
                    if (r_baud_cnt == C_SAMPLE) begin
                        r_state    <= IDLE;
                        r_baud_cnt <= '0;
                        if (w_bit) begin
                            data    <= r_shift_reg;
                            rx_done <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx at 50 MHz / 5 Mbaud (10 clocks per bit).
module tb_uart_byte_rx;

    localparam int BIT_CLKS = 10;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = 99;
`else
    localparam int LAT = 98;
`endif

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [7:0] byte_in;
        logic       stop_bit;
        int         idle_after;
        logic       exp_err;
        logic [7:0] exp_data;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx = 1'b1;
    logic [7:0] data;
    logic       rx_done;
    logic       frame_err;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[6];

    uart_byte_rx #(
        .clock_freq (50_000_000),
        .baud       (5_000_000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .data      (data),
        .rx_done   (rx_done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Drives one frame starting at the next falling clock edge; optionally
    // flips the mid-bit sample of each data bit, or resets during a data bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int reset_bit,
                              input logic flip, input logic push, input logic exp_err,
                              input logic [7:0] exp_data);
        logic [9:0] bits;
        exp_t       e;
        bits = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < BIT_CLKS; k++) begin
                @(negedge clk);
                if (i == 0 && k == 0 && push) begin
                    e.is_err = exp_err;
                    e.data   = exp_data;
                    e.cyc    = cyc + LAT;
                    sb.push_back(e);
                end
                if (k == 0) uart_rx = bits[i];
                if (flip && i >= 1 && i <= 8 && k == 5) uart_rx = ~bits[i];
                if (k == 6) uart_rx = bits[i];
                if (reset_bit >= 0 && i == reset_bit + 1 && k == 5) begin
                    reset   = 1'b1;
                    uart_rx = 1'b1;
                    @(negedge clk);
                    reset = 1'b0;
                    return;
                end
            end
        end
    endtask

    // Scoreboard: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rx_done && frame_err) begin
            check("strobe_exclusive", 32'd1, 32'd0);
        end else if (rx_done || frame_err) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", {30'd0, rx_done, frame_err}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("strobe_kind", {31'd0, frame_err}, {31'd0, mon_e.is_err});
                check("strobe_data", {24'd0, data}, {24'd0, mon_e.data});
                check("strobe_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 20, 1'b0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1,  0, 1'b0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1,  0, 1'b0, 8'hFF};
        vecs[3] = '{8'h3C, 1'b1, 20, 1'b0, 8'h3C};
        vecs[4] = '{8'h55, 1'b0, 20, 1'b1, 8'h3C};
        vecs[5] = '{8'h12, 1'b1, 20, 1'b0, 8'h12};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_data", {24'd0, data}, 32'h0);
        check("reset_rx_done", {31'd0, rx_done}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);

        // Reset during data bit 3 discards the partial byte.
        send_frame(8'hC3, 1'b1, 3, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (120) @(negedge clk);
        check("data_after_midframe_reset", {24'd0, data}, 32'h0);
        send_frame(8'h81, 1'b1, -1, 1'b0, 1'b1, 1'b0, 8'h81);
        repeat (20) begin @(negedge clk); uart_rx = 1'b1; end

        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].byte_in, vecs[v].stop_bit, -1, 1'b0, 1'b1,
                       vecs[v].exp_err, vecs[v].exp_data);
            repeat (vecs[v].idle_after) begin @(negedge clk); uart_rx = 1'b1; end
        end

        // Short glitch must abort in START; a frame right behind it still lands.
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (6) @(negedge clk);
        send_frame(8'h7E, 1'b1, -1, 1'b0, 1'b1, 1'b0, 8'h7E);
        repeat (20) begin @(negedge clk); uart_rx = 1'b1; end

`ifdef UART_RX_MAJORITY_EN
        send_frame(8'h96, 1'b1, -1, 1'b1, 1'b1, 1'b0, 8'h96);
        repeat (20) begin @(negedge clk); uart_rx = 1'b1; end
`endif

        repeat (150) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
